// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order multi-slot commit, multi-channel CDB completion
// and branch-mispredict flush. Head/tail carry a wrap bit to tell full from empty.
module rob_multi_commit #(
   parameter int DEPTH    = 16,
   parameter int ARCH_W   = 5,
   parameter int PHY_W    = 7,
   parameter int NUM_CDB  = 2,
   parameter int COMMIT_W = 2,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        alloc_valid,
   input  logic [ARCH_W-1:0]           alloc_arch_reg,
   input  logic [PHY_W-1:0]            alloc_phy_reg,
   input  logic                        alloc_has_dest,
   output logic                        alloc_ready,
   output logic [TAG_W-1:0]            alloc_tag,
   input  logic [NUM_CDB-1:0]          cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
   input  logic [NUM_CDB-1:0]          cdb_mispredict,
   output logic [COMMIT_W-1:0]         commit_valid,
   output logic [COMMIT_W*ARCH_W-1:0]  commit_arch_reg,
   output logic [COMMIT_W*PHY_W-1:0]   commit_phy_reg,
   output logic [COMMIT_W*TAG_W-1:0]   commit_tag,
   output logic [COMMIT_W-1:0]         commit_has_dest,
   output logic                        flush,
   output logic [TAG_W-1:0]            flush_tag,
   output logic                        rob_full,
   output logic                        rob_empty,
   output logic [TAG_W:0]              rob_count
);

   logic [TAG_W:0]      head;
   logic [TAG_W:0]      tail;
   logic [DEPTH-1:0]    entry_valid;
   logic [DEPTH-1:0]    entry_done;
   logic [DEPTH-1:0]    entry_mispred;
   logic [ARCH_W-1:0]   entry_arch [DEPTH];
   logic [PHY_W-1:0]    entry_phy  [DEPTH];
   logic [DEPTH-1:0]    entry_has_dest;

   logic [TAG_W-1:0]    head_idx;
   logic [TAG_W-1:0]    tail_idx;
   logic [TAG_W-1:0]    slot_idx;
   logic                chain_ok;
   logic [TAG_W:0]      commit_cnt;
   logic                commit_mispred;
   logic [TAG_W-1:0]    commit_mp_tag;
   logic                alloc_fire;

   // Status and allocation handshake, all from registered state.
   always_comb begin
      head_idx    = head[TAG_W-1:0];
      tail_idx    = tail[TAG_W-1:0];
      rob_empty   = (head == tail);
      rob_full    = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
      rob_count   = tail - head;
      alloc_ready = !rob_full && !flush;
      alloc_tag   = tail_idx;
      alloc_fire  = alloc_valid && alloc_ready;
   end

   // Commit window: longest run of valid+done entries from head, cut just after a mispredict.
   always_comb begin
      commit_valid    = '0;
      commit_arch_reg = '0;
      commit_phy_reg  = '0;
      commit_tag      = '0;
      commit_has_dest = '0;
      commit_cnt      = '0;
      commit_mispred  = 1'b0;
      commit_mp_tag   = '0;
      chain_ok        = 1'b1;
      slot_idx        = '0;
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         slot_idx = head[TAG_W-1:0] + TAG_W'(k);
         chain_ok = chain_ok && entry_valid[slot_idx] && entry_done[slot_idx];
         if (chain_ok) begin
            commit_valid[k]                     = 1'b1;
            commit_arch_reg[k*ARCH_W +: ARCH_W] = entry_arch[slot_idx];
            commit_phy_reg[k*PHY_W +: PHY_W]    = entry_phy[slot_idx];
            commit_tag[k*TAG_W +: TAG_W]        = slot_idx;
            commit_has_dest[k]                  = entry_has_dest[slot_idx];
            commit_cnt                          = commit_cnt + (TAG_W+1)'(1);
            if (entry_mispred[slot_idx]) begin
               commit_mispred = 1'b1;
               commit_mp_tag  = slot_idx;
            end
            chain_ok = !entry_mispred[slot_idx];
         end
      end
   end

   // Entry state, pointers and flush: completion, then commit, then allocation; a mispredict commit overrides all.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head           <= '0;
         tail           <= '0;
         entry_valid    <= '0;
         entry_done     <= '0;
         entry_mispred  <= '0;
         entry_has_dest <= '0;
         flush          <= 1'b0;
         flush_tag      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_arch[i] <= '0;
            entry_phy[i]  <= '0;
         end
      end else begin
         if (!flush) begin
            for (int unsigned c = 0; c < NUM_CDB; c++) begin
               if (cdb_valid[c] && entry_valid[cdb_tag[c*TAG_W +: TAG_W]]) begin
                  entry_done[cdb_tag[c*TAG_W +: TAG_W]] <= 1'b1;
                  if (cdb_mispredict[c])
                     entry_mispred[cdb_tag[c*TAG_W +: TAG_W]] <= 1'b1;
               end
            end
         end
         for (int unsigned k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k])
               entry_valid[head_idx + TAG_W'(k)] <= 1'b0;
         end
         head <= head + commit_cnt;
         if (commit_mispred) begin
            entry_valid <= '0;
            tail        <= head + commit_cnt;
            flush       <= 1'b1;
            flush_tag   <= commit_mp_tag;
         end else begin
            flush     <= 1'b0;
            flush_tag <= '0;
            if (alloc_fire) begin
               entry_valid[tail_idx]    <= 1'b1;
               entry_done[tail_idx]     <= 1'b0;
               entry_mispred[tail_idx]  <= 1'b0;
               entry_arch[tail_idx]     <= alloc_arch_reg;
               entry_phy[tail_idx]      <= alloc_phy_reg;
               entry_has_dest[tail_idx] <= alloc_has_dest;
               tail                     <= tail + (TAG_W+1)'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the ROB.
module tb_rob_multi_commit;

   localparam int DEPTH    = 16;
   localparam int COMMIT_W = 2;

   logic        clk;
   logic        reset;
   logic        alloc_valid;
   logic [4:0]  alloc_arch_reg;
   logic [6:0]  alloc_phy_reg;
   logic        alloc_has_dest;
   logic        alloc_ready;
   logic [3:0]  alloc_tag;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_tag;
   logic [1:0]  cdb_mispredict;
   logic [1:0]  commit_valid;
   logic [9:0]  commit_arch_reg;
   logic [13:0] commit_phy_reg;
   logic [7:0]  commit_tag;
   logic [1:0]  commit_has_dest;
   logic        flush;
   logic [3:0]  flush_tag;
   logic        rob_full;
   logic        rob_empty;
   logic [4:0]  rob_count;

   rob_multi_commit #(
      .DEPTH(16), .ARCH_W(5), .PHY_W(7), .NUM_CDB(2), .COMMIT_W(2)
   ) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_arch_reg(alloc_arch_reg),
      .alloc_phy_reg(alloc_phy_reg), .alloc_has_dest(alloc_has_dest),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_mispredict(cdb_mispredict),
      .commit_valid(commit_valid), .commit_arch_reg(commit_arch_reg),
      .commit_phy_reg(commit_phy_reg), .commit_tag(commit_tag),
      .commit_has_dest(commit_has_dest),
      .flush(flush), .flush_tag(flush_tag),
      .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: queue of live entries, oldest first; tags follow from the head tag.
   typedef struct {
      logic [3:0] tag;
      logic [4:0] arch;
      logic [6:0] phy;
      logic       hd;
      bit         done;
      bit         mp;
   } ent_t;

   ent_t       q[$];
   int         hp = 0;
   bit         m_flush = 0;
   logic [3:0] m_ftag = '0;

   // One clock: called at a falling edge, checks outputs, drives inputs, advances model.
   task automatic step(input logic av, input logic [4:0] ar, input logic [6:0] pr, input logic hd,
                       input logic [1:0] cv, input logic [7:0] ct, input logic [1:0] cm);
      logic [1:0]  ecv, ehd;
      logic [9:0]  ear;
      logic [13:0] epr;
      logic [7:0]  etg;
      logic [3:0]  ftag;
      int          n, size0, ntag;
      bit          fl, stop, ready;
      ecv = '0; ehd = '0; ear = '0; epr = '0; etg = '0; ftag = '0;
      n = 0; fl = 0; stop = 0;
      size0 = q.size();
      for (int i = 0; i < COMMIT_W; i++) begin
         if (!stop && i < size0 && q[i].done) begin
            ecv[i]         = 1'b1;
            ear[i*5 +: 5]  = q[i].arch;
            epr[i*7 +: 7]  = q[i].phy;
            etg[i*4 +: 4]  = q[i].tag;
            ehd[i]         = q[i].hd;
            n++;
            if (q[i].mp) begin
               fl   = 1;
               ftag = q[i].tag;
               stop = 1;
            end
         end else begin
            stop = 1;
         end
      end
      ready = (size0 < DEPTH) && !m_flush;
      ntag  = (hp + size0) % DEPTH;

      check("alloc_ready",  64'(alloc_ready),     64'(ready));
      check("alloc_tag",    64'(alloc_tag),       64'(ntag));
      check("rob_full",     64'(rob_full),        64'(size0 == DEPTH));
      check("rob_empty",    64'(rob_empty),       64'(size0 == 0));
      check("rob_count",    64'(rob_count),       64'(size0));
      check("commit_valid", 64'(commit_valid),    64'(ecv));
      check("commit_arch",  64'(commit_arch_reg), 64'(ear));
      check("commit_phy",   64'(commit_phy_reg),  64'(epr));
      check("commit_tag",   64'(commit_tag),      64'(etg));
      check("commit_hd",    64'(commit_has_dest), 64'(ehd));
      check("flush",        64'(flush),           64'(m_flush));
      check("flush_tag",    64'(flush_tag),       64'(m_ftag));

      alloc_valid    = av;
      alloc_arch_reg = ar;
      alloc_phy_reg  = pr;
      alloc_has_dest = hd;
      cdb_valid      = cv;
      cdb_tag        = ct;
      cdb_mispredict = cm;

      repeat (n) void'(q.pop_front());
      hp = (hp + n) % DEPTH;
      if (fl) begin
         q.delete();
         m_flush = 1;
         m_ftag  = ftag;
      end else begin
         if (!m_flush) begin
            for (int j = 0; j < q.size(); j++)
               for (int c = 0; c < 2; c++)
                  if (cv[c] && q[j].tag == ct[c*4 +: 4]) begin
                     q[j].done = 1;
                     if (cm[c]) q[j].mp = 1;
                  end
         end
         if (av && ready)
            q.push_back('{tag: 4'(ntag), arch: ar, phy: pr, hd: hd, done: 1'b0, mp: 1'b0});
         m_flush = 0;
         m_ftag  = '0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b00, 8'h00, 2'b00);
   endtask

   task automatic alloc_one(input logic [4:0] ar, input logic [6:0] pr, input logic hd);
      step(1'b1, ar, pr, hd, 2'b00, 8'h00, 2'b00);
   endtask

   // Asserted between clock edges so the asynchronous clear is observed right away.
   task automatic do_reset();
      alloc_valid = 0; alloc_arch_reg = '0; alloc_phy_reg = '0; alloc_has_dest = 0;
      cdb_valid = '0; cdb_tag = '0; cdb_mispredict = '0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_rob_empty",    64'(rob_empty),    64'd1);
      check("rst_rob_full",     64'(rob_full),     64'd0);
      check("rst_rob_count",    64'(rob_count),    64'd0);
      check("rst_flush",        64'(flush),        64'd0);
      check("rst_flush_tag",    64'(flush_tag),    64'd0);
      check("rst_alloc_tag",    64'(alloc_tag),    64'd0);
      @(negedge clk);
      reset   = 1'b0;
      q.delete();
      hp      = 0;
      m_flush = 0;
      m_ftag  = '0;
   endtask

   initial begin
      logic        seen;
      logic        rav, rhd;
      logic [4:0]  rar;
      logic [6:0]  rpr;
      logic [1:0]  rcv, rcm;
      logic [7:0]  rct;
      logic [3:0]  t;

      reset = 1'b1;
      alloc_valid = 0; alloc_arch_reg = '0; alloc_phy_reg = '0; alloc_has_dest = 0;
      cdb_valid = '0; cdb_tag = '0; cdb_mispredict = '0;
      @(negedge clk);
      do_reset();

      // Out-of-order completion, two commits in one cycle, younger entry waits.
      alloc_one(5'd1, 7'd11, 1'b1);
      alloc_one(5'd2, 7'd12, 1'b0);
      alloc_one(5'd3, 7'd13, 1'b1);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b01, 8'h01, 2'b00);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b01, 8'h00, 2'b00);
      check("r034_cv",   64'(commit_valid), 64'h3);
      check("r034_tags", 64'(commit_tag),   64'h10);
      idle();
      check("r034_wait_cv",    64'(commit_valid), 64'h0);
      check("r034_wait_count", 64'(rob_count),    64'd1);

      // Fill to capacity, refuse the extra request, then wrap the tail to tag 0.
      do_reset();
      for (int i = 0; i < DEPTH; i++) alloc_one(5'(i), 7'(i + 40), 1'b1);
      check("r035_full",  64'(rob_full),    64'd1);
      check("r035_count", 64'(rob_count),   64'd16);
      check("r035_ready", 64'(alloc_ready), 64'd0);
      alloc_one(5'd30, 7'd99, 1'b1);
      check("r035_tail", 64'(alloc_tag), 64'd0);
      step(1'b1, 5'd30, 7'd99, 1'b1, 2'b01, 8'h00, 2'b00);
      step(1'b1, 5'd30, 7'd99, 1'b1, 2'b00, 8'h00, 2'b00);
      check("r036_ready", 64'(alloc_ready), 64'd1);
      check("r036_tag",   64'(alloc_tag),   64'd0);
      alloc_one(5'd30, 7'd99, 1'b1);
      check("r036_count", 64'(rob_count), 64'd16);

      // Mispredict on tag 4 retires 3 and 4 together, then flushes 5..7.
      do_reset();
      for (int i = 0; i < 3; i++) alloc_one(5'(i), 7'(i), 1'b0);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b11, 8'h10, 2'b00);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b01, 8'h02, 2'b00);
      idle();
      for (int i = 3; i < 8; i++) alloc_one(5'(i), 7'(i + 20), 1'b1);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b11, 8'h34, 2'b01);
      check("r037_cv",   64'(commit_valid), 64'h3);
      check("r037_tags", 64'(commit_tag),   64'h43);
      idle();
      check("r037_flush",     64'(flush),     64'd1);
      check("r037_flush_tag", 64'(flush_tag), 64'd4);
      check("r037_empty",     64'(rob_empty), 64'd1);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b11, 8'h65, 2'b00);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b01, 8'h07, 2'b00);
      idle();

      // Two channels hit tag 5, only one flags mispredict.
      do_reset();
      for (int i = 0; i < 6; i++) alloc_one(5'(i), 7'(i + 60), 1'b1);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b11, 8'h10, 2'b00);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b11, 8'h32, 2'b00);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b01, 8'h04, 2'b00);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b11, 8'h55, 2'b10);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (flush && flush_tag == 4'd5) seen = 1'b1;
         idle();
      end
      check("r038_flush_seen", 64'(seen), 64'd1);

      // Reset with eight live entries and a mispredict commit about to flush.
      do_reset();
      for (int i = 0; i < 8; i++) alloc_one(5'(i), 7'(i), 1'b1);
      step(1'b0, 5'd0, 7'd0, 1'b0, 2'b01, 8'h00, 2'b01);
      check("r039_pending", 64'(commit_valid), 64'h1);
      do_reset();
      idle();
      check("r039_no_flush", 64'(flush), 64'd0);
      idle();

      // Random traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         rav = ($urandom_range(0, 9) < 7);
         rar = 5'($urandom);
         rpr = 7'($urandom);
         rhd = 1'($urandom);
         rcv = '0; rct = '0; rcm = '0;
         for (int c = 0; c < 2; c++) begin
            rcv[c] = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
               t = q[$urandom_range(0, q.size() - 1)].tag;
            else
               t = 4'($urandom);
            rct[c*4 +: 4] = t;
            rcm[c] = ($urandom_range(0, 39) == 0);
         end
         step(rav, rar, rpr, rhd, rcv, rct, rcm);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rob_multi_commit.md
ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

Interface
REQ-001 Parameter DEPTH, default 16: entry count; power of two, minimum 4.
REQ-002 Parameter ARCH_W, default 5: architectural register index width.
REQ-003 Parameter PHY_W, default 7: physical register index width.
REQ-004 Parameter NUM_CDB, default 2: CDB writeback channels, 1 to 4.
REQ-005 Parameter COMMIT_W, default 2: maximum commits per cycle, 1 to 4; TAG_W = log2(DEPTH).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; clears all state.
REQ-008 alloc_valid  in  1  dispatch request.
REQ-009 alloc_arch_reg  in  ARCH_W  destination architectural register.
REQ-010 alloc_phy_reg  in  PHY_W  destination physical register.
REQ-011 alloc_has_dest  in  1  instruction writes a register.
REQ-012 alloc_ready  out  1  allocation accepted this cycle.
REQ-013 alloc_tag  out  TAG_W  tag assigned to a request this cycle (tail index).
REQ-014 cdb_valid  in  NUM_CDB  per-channel completion strobe.
REQ-015 cdb_tag  in  NUM_CDB*TAG_W  per-channel completed tag, channel 0 in LSBs.
REQ-016 cdb_mispredict  in  NUM_CDB  completing branch was mispredicted.
REQ-017 commit_valid  out  COMMIT_W  per-slot retire strobe, slot 0 oldest.
REQ-018 commit_arch_reg  out  COMMIT_W*ARCH_W; commit_phy_reg  out  COMMIT_W*PHY_W; commit_tag  out  COMMIT_W*TAG_W; commit_has_dest  out  COMMIT_W.
REQ-019 flush  out  1  one-cycle pipeline flush; flush_tag  out  TAG_W  tag of the mispredicted branch.
REQ-020 rob_full, rob_empty  out  1 each; rob_count  out  TAG_W+1  occupied entries.

Function
REQ-021 Circular buffer; head/tail pointers of TAG_W+1 bits (wrap bit); full when indices equal and wrap bits differ, empty when pointers equal.
REQ-022 alloc_ready = !rob_full && !flush, from registered state only; no same-cycle commit bypass.
REQ-023 alloc_valid && alloc_ready writes entry at tail (valid=1, done=0, mispred=0, fields) and advances tail by 1 at the edge.
REQ-024 Per channel, cdb_valid with a tag of a valid entry sets done; mispredict bit ORed in; completions to invalid entries ignored; multiple channels to one tag ORed.
REQ-025 Completion to an entry being allocated in the same cycle is ignored (allocation wins).
REQ-026 Commit combinational from registered state: slot k valid iff entries head..head+k all valid and done, and no mispredicted entry in slots 0..k-1.
REQ-027 Committed entries are invalidated and head advances by popcount(commit_valid) at the edge; commit latency after completion is exactly 1 cycle.
REQ-028 When a committed slot carries mispred: at that edge, all younger entries invalidated, tail := new head, same-cycle allocation discarded; flush=1 and flush_tag registered for exactly the next cycle.
REQ-029 During the flush cycle alloc_ready=0 and cdb inputs ignored; normal operation resumes the following cycle.
REQ-030 rob_count = tail - head (TAG_W+1 bit modular subtraction), updated each edge with allocate and commit in the same cycle.
REQ-031 Empty ROB: commit_valid all 0; inactive commit slot data fields drive 0.

Reset
REQ-032 On reset assertion, immediately: head=tail=0, all valid/done/mispred=0, flush=0, flush_tag=0, commit_valid=0, rob_empty=1, rob_full=0, rob_count=0, alloc_tag=0.
REQ-033 Reset mid-operation discards all entries and any pending flush; no commit reported in the cycle after deassertion.

Verification
REQ-034 Reset, allocate tags 0,1,2; CDB completes 1 then 0 -> cycle after tag-0 completion commit_valid=2'b11 with tags 0,1; tag 2 waits.
REQ-035 DEPTH=16: 16 allocations, none completed -> rob_full=1, rob_count=16, alloc_ready=0; 17th request not accepted, tail unchanged.
REQ-036 Full ROB, complete head, alloc same cycle -> alloc refused that cycle, accepted next cycle at tag 0 (wrap), rob_count back to 16.
REQ-037 Tags 3..7 allocated, tag 4 completes mispredict, 3 done -> commits 3,4 together, flush=1 flush_tag=4 next cycle, rob_empty=1, tags 5..7 never commit.
REQ-038 Two CDB channels complete same tag 5, one with mispredict -> entry 5 done with mispred; flush after its commit.
REQ-039 Assert reset while 8 entries valid and flush pending -> all outputs at reset values immediately; no flush after deassertion.
